// File: rtl/conv1d_stride.sv
// rtl/conv1d_stride.sv - strided 1-D convolution with saturating MAC and optional ReLU
module conv1d_stride #(
  parameter int N    = 16,
  parameter int M    = 4,
  parameter int T    = 8,
  parameter int S    = 1,
  parameter int RELU = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [T-1:0] x_data,
  input  logic         x_valid,
  output logic         x_ready,
  input  logic [T-1:0] f_data,
  input  logic         f_valid,
  output logic         f_ready,
  output logic [T-1:0] y_data,
  output logic         y_valid,
  input  logic         y_ready,
  output logic         y_last
);

  localparam int L  = (N - M) / S + 1;
  localparam int XW = $clog2(N) + 1;
  localparam int FW = $clog2(M) + 1;
  localparam int LW = $clog2(L) + 1;

  localparam logic [XW-1:0] N_X  = XW'(N);
  localparam logic [XW-1:0] S_X  = XW'(S);
  localparam logic [FW-1:0] M_F  = FW'(M);
  localparam logic [FW-1:0] M1_F = FW'(M - 1);
  localparam logic [FW-1:0] ONE_F = FW'(1);
  localparam logic [LW-1:0] L1_L = LW'(L - 1);
  localparam logic [T-1:0]  SMAX = {1'b0, {(T-1){1'b1}}};
  localparam logic [T-1:0]  SMIN = {1'b1, {(T-1){1'b0}}};

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] CLEAR = 3'd2;
  localparam logic [2:0] FILL  = 3'd3;
  localparam logic [2:0] MAC   = 3'd4;
  localparam logic [2:0] OUT   = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [XW-1:0] x_cnt_q, x_cnt_d;
  logic [FW-1:0] f_cnt_q, f_cnt_d;
  logic [XW-1:0] base_q;
  logic [FW-1:0] k_q;
  logic [FW-1:0] step_q;
  logic [LW-1:0] n_q;
  logic [T-1:0]  acc_q;
  logic [T-1:0]  prod_q;
  logic [T-1:0]  y_data_q;
  logic          y_last_q;

  logic [T-1:0]  x_ram [N];
  logic [T-1:0]  f_ram [M];
  logic [T-1:0]  x_rd_q, f_rd_q;

  logic          x_fire, f_fire, y_fire;
  logic          load_done, fill_done, mac_last, n_last;
  logic [XW-1:0] rd_addr;
  logic [2*T-1:0] prod_full;
  logic          prod_ok;
  logic [T-1:0]  prod_sat;
  logic [T:0]    sum;
  logic [T-1:0]  sum_sat;
  logic [T-1:0]  y_next;

  assign x_ready   = (state_q == LOAD) && (x_cnt_q != N_X);
  assign f_ready   = (state_q == LOAD) && (f_cnt_q != M_F);
  assign x_fire    = x_valid && x_ready;
  assign f_fire    = f_valid && f_ready;
  assign x_cnt_d   = x_cnt_q + XW'(x_fire);
  assign f_cnt_d   = f_cnt_q + FW'(f_fire);
  assign load_done = (x_cnt_d == N_X) && (f_cnt_d == M_F);
  assign fill_done = (step_q == ONE_F);
  assign mac_last  = (step_q == M1_F);
  assign n_last    = (n_q == L1_L);
  assign y_fire    = (state_q == OUT) && y_ready;

  assign y_valid = (state_q == OUT);
  assign y_last  = (state_q == OUT) && y_last_q;
  assign y_data  = y_data_q;

  // Window start plus tap index; k stops at M-1 so this never passes N-1.
  assign rd_addr = base_q + XW'(k_q);

  // Sign-extended product, clamped to the T-bit range.
  assign prod_full = $signed({{T{x_rd_q[T-1]}}, x_rd_q}) * $signed({{T{f_rd_q[T-1]}}, f_rd_q});
  assign prod_ok   = (&prod_full[2*T-1:T-1]) | ~(|prod_full[2*T-1:T-1]);
  assign prod_sat  = prod_ok ? prod_full[T-1:0] : (prod_full[2*T-1] ? SMIN : SMAX);

  // Accumulate with one extra bit so overflow shows as a sign disagreement.
  assign sum     = {acc_q[T-1], acc_q} + {prod_q[T-1], prod_q};
  assign sum_sat = (sum[T] == sum[T-1]) ? sum[T-1:0] : (sum[T] ? SMIN : SMAX);
  assign y_next  = ((RELU != 0) && sum_sat[T-1]) ? '0 : sum_sat;

  // Next-state selection for the load / compute / output sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = LOAD;
      LOAD:  if (load_done) state_d = CLEAR;
      CLEAR: state_d = FILL;
      FILL:  if (fill_done) state_d = MAC;
      MAC:   if (mac_last) state_d = OUT;
      OUT:   if (y_fire) state_d = n_last ? LOAD : CLEAR;
      default: state_d = IDLE;
    endcase
  end

  // Control counters, accumulator and the held output word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      x_cnt_q  <= '0;
      f_cnt_q  <= '0;
      base_q   <= '0;
      k_q      <= '0;
      step_q   <= '0;
      n_q      <= '0;
      acc_q    <= '0;
      y_data_q <= '0;
      y_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        LOAD: begin
          if (load_done) begin
            x_cnt_q <= '0;
            f_cnt_q <= '0;
          end else begin
            x_cnt_q <= x_cnt_d;
            f_cnt_q <= f_cnt_d;
          end
        end
        CLEAR: begin
          acc_q  <= '0;
          k_q    <= '0;
          step_q <= '0;
        end
        FILL: begin
          if (k_q != M1_F) k_q <= k_q + ONE_F;
          step_q <= fill_done ? '0 : step_q + ONE_F;
        end
        MAC: begin
          if (k_q != M1_F) k_q <= k_q + ONE_F;
          acc_q  <= sum_sat;
          step_q <= step_q + ONE_F;
          if (mac_last) begin
            y_data_q <= y_next;
            y_last_q <= n_last;
          end
        end
        OUT: begin
          if (y_fire) begin
            if (n_last) begin
              n_q    <= '0;
              base_q <= '0;
            end else begin
              n_q    <= n_q + LW'(1);
              base_q <= base_q + S_X;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Sample and coefficient RAMs; the guard bits gate any out-of-range read.
  always_ff @(posedge clk) begin
    if (x_fire) x_ram[x_cnt_q[XW-2:0]] <= x_data;
    if (f_fire) f_ram[f_cnt_q[FW-2:0]] <= f_data;
    if (!rd_addr[XW-1]) x_rd_q <= x_ram[rd_addr[XW-2:0]];
    if (!k_q[FW-1]) f_rd_q <= f_ram[k_q[FW-2:0]];
  end

  // Product register stage between the RAM reads and the accumulator.
  always_ff @(posedge clk) begin
    prod_q <= prod_sat;
  end

endmodule

// File: tb/tb_conv1d_stride.sv
// tb/tb_conv1d_stride.sv - scoreboard bench for conv1d_stride (S=1 ReLU and S=2 signed instances)
module tb_conv1d_stride;

  localparam int N = 16;
  localparam int M = 4;
  localparam int T = 8;

  typedef struct {
    int y;
    bit last;
  } sb_t;

  typedef struct {
    int sel;
    int xmode;
    int xval;
    int f0, f1, f2, f3;
    int cnt;
    int y0;
    int ylast;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst [2];
  logic [T-1:0] xd [2];
  logic         xv [2];
  logic         xr [2];
  logic [T-1:0] fd [2];
  logic         fv [2];
  logic         fr [2];
  logic [T-1:0] yd [2];
  logic         yv [2];
  logic         yr [2];
  logic         yl [2];

  conv1d_stride #(.N(N), .M(M), .T(T), .S(1), .RELU(1)) dut0 (
    .clk(clk), .reset(rst[0]),
    .x_data(xd[0]), .x_valid(xv[0]), .x_ready(xr[0]),
    .f_data(fd[0]), .f_valid(fv[0]), .f_ready(fr[0]),
    .y_data(yd[0]), .y_valid(yv[0]), .y_ready(yr[0]), .y_last(yl[0])
  );

  conv1d_stride #(.N(N), .M(M), .T(T), .S(2), .RELU(0)) dut1 (
    .clk(clk), .reset(rst[1]),
    .x_data(xd[1]), .x_valid(xv[1]), .x_ready(xr[1]),
    .f_data(fd[1]), .f_valid(fv[1]), .f_ready(fr[1]),
    .y_data(yd[1]), .y_valid(yv[1]), .y_ready(yr[1]), .y_last(yl[1])
  );

  int checks = 0;
  int errors = 0;

  sb_t sbq0[$];
  sb_t sbq1[$];

  int cyc = 0;
  int ref_cyc [2] = '{-1, -1};
  int xcnt [2] = '{0, 0};
  int fcnt [2] = '{0, 0};
  bit prev_v [2] = '{0, 0};
  int prev_d [2] = '{0, 0};
  bit prev_l [2] = '{0, 0};
  bit prev_fire [2] = '{0, 0};
  int pass_cnt [2] = '{0, 0};
  int first_y [2] = '{0, 0};
  int last_y [2] = '{0, 0};
  bit pass_done [2] = '{0, 0};
  bit xdone [2] = '{0, 0};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  function automatic int sat(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  // Reference model: saturate every product and every partial sum.
  task automatic push_model(input int i, input int xs[16], input int fs[4]);
    int s;
    int l;
    int acc;
    sb_t e;
    s = (i == 0) ? 1 : 2;
    l = (N - M) / s + 1;
    for (int n = 0; n < l; n++) begin
      acc = 0;
      for (int k = 0; k < M; k++) acc = sat(acc + sat(xs[n * s + k] * fs[k]));
      if (i == 0 && acc < 0) acc = 0;
      e.y = acc;
      e.last = (n == l - 1);
      if (i == 0) sbq0.push_back(e);
      else sbq1.push_back(e);
    end
  endtask

  task automatic monitor_step(input int i);
    bit fire;
    int y;
    sb_t e;
    if (rst[i]) begin
      xcnt[i] = 0;
      fcnt[i] = 0;
      ref_cyc[i] = -1;
      prev_v[i] = 0;
      prev_fire[i] = 0;
    end else begin
      y = int'($signed(yd[i]));
      if (prev_v[i] && !prev_fire[i]) begin
        chk("hold_valid", int'(yv[i]), 1);
        chk("hold_data", y, prev_d[i]);
        chk("hold_last", int'(yl[i]), int'(prev_l[i]));
      end
      if (!yv[i]) chk("last_without_valid", int'(yl[i]), 0);
      if (yv[i] && !prev_v[i] && ref_cyc[i] >= 0) chk("valid_latency", cyc - ref_cyc[i], M + 4);
      fire = yv[i] && yr[i];
      if (fire) begin
        if ((i == 0 && sbq0.size() == 0) || (i == 1 && sbq1.size() == 0)) begin
          fail("unexpected_output");
        end else begin
          if (i == 0) e = sbq0.pop_front();
          else e = sbq1.pop_front();
          chk("y_data", y, e.y);
          chk("y_last", int'(yl[i]), int'(e.last));
        end
        if (pass_cnt[i] == 0) first_y[i] = y;
        pass_cnt[i]++;
        if (yl[i]) begin
          last_y[i] = y;
          pass_done[i] = 1;
          ref_cyc[i] = -1;
        end else begin
          ref_cyc[i] = cyc;
        end
      end
      if (xv[i] && xr[i]) xcnt[i]++;
      if (fv[i] && fr[i]) fcnt[i]++;
      if (xcnt[i] == N && fcnt[i] == M) begin
        ref_cyc[i] = cyc;
        xcnt[i] = 0;
        fcnt[i] = 0;
      end
      prev_v[i] = yv[i];
      prev_d[i] = y;
      prev_l[i] = yl[i];
      prev_fire[i] = fire;
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    monitor_step(0);
    monitor_step(1);
  end

  task automatic wait_beat(input int i, input bit is_f);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(is_f ? fr[i] : xr[i]) && t < 300);
    if (!(is_f ? fr[i] : xr[i])) fail(is_f ? "f_ready_timeout" : "x_ready_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int i, input int xs[16], input int fs[4], input int fdelay,
                      input int nx, input int nf, input bit gaps);
    xdone[i] = 0;
    fork
      begin
        for (int k = 0; k < nx; k++) begin
          if (gaps && $urandom_range(0, 2) == 0) begin
            xv[i] = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
          xv[i] = 1'b1;
          xd[i] = 8'(xs[k]);
          wait_beat(i, 1'b0);
        end
        xv[i] = 1'b0;
        xdone[i] = 1;
      end
      begin
        if (fdelay > 0) begin
          wait (xdone[i]);
          repeat (fdelay) @(posedge clk);
          @(negedge clk);
          chk("x_ready_after_full", int'(xr[i]), 0);
          chk("f_ready_while_waiting", int'(fr[i]), 1);
          chk("no_output_while_loading", int'(yv[i]), 0);
          @(posedge clk);
          #1;
        end
        for (int k = 0; k < nf; k++) begin
          if (gaps && $urandom_range(0, 2) == 0) begin
            fv[i] = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
          fv[i] = 1'b1;
          fd[i] = 8'(fs[k]);
          wait_beat(i, 1'b1);
        end
        fv[i] = 1'b0;
      end
    join
  endtask

  task automatic start_pass(input int i, input int xs[16], input int fs[4]);
    push_model(i, xs, fs);
    pass_done[i] = 0;
    pass_cnt[i] = 0;
    first_y[i] = 0;
    last_y[i] = 0;
  endtask

  task automatic wait_done(input int i);
    int t;
    t = 0;
    while (!pass_done[i] && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (!pass_done[i]) fail("pass_timeout");
    chk("scoreboard_drained", (i == 0) ? sbq0.size() : sbq1.size(), 0);
  endtask

  task automatic reset_dut(input int i);
    rst[i] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst[i] = 1'b0;
  endtask

  task automatic check_reset_outputs(input int i);
    chk("rst_x_ready", int'(xr[i]), 0);
    chk("rst_f_ready", int'(fr[i]), 0);
    chk("rst_y_valid", int'(yv[i]), 0);
    chk("rst_y_last", int'(yl[i]), 0);
    chk("rst_y_data", int'(yd[i]), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [6];
    int xs [16];
    int fs [4];
    int ramp [16];
    int rx [16];
    int rf [4];
    int t;
    int d0;
    int l0;

    vecs[0] = '{0, 0, 0,    1,    1,    1,    1, 13,   10,   58};
    vecs[1] = '{1, 0, 0,    1,    1,    1,    1,  7,   10,   58};
    vecs[2] = '{0, 1, 127,  127,  127,  127,  127, 13,  127,  127};
    vecs[3] = '{1, 1, 127, -128, -128, -128, -128,  7, -128, -128};
    vecs[4] = '{0, 0, 0,   -1,   -1,   -1,   -1, 13,    0,    0};
    vecs[5] = '{1, 0, 0,   -1,   -1,   -1,   -1,  7,  -10,  -58};

    for (int k = 0; k < N; k++) ramp[k] = k + 1;

    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1;
      xv[i] = 1'b0;
      fv[i] = 1'b0;
      xd[i] = '0;
      fd[i] = '0;
      yr[i] = 1'b1;
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs(0);
    check_reset_outputs(1);
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("load_x_ready", int'(xr[i]), 1);
      chk("load_f_ready", int'(fr[i]), 1);
    end

    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < N; k++) xs[k] = (vecs[v].xmode == 0) ? ramp[k] : vecs[v].xval;
      fs[0] = vecs[v].f0;
      fs[1] = vecs[v].f1;
      fs[2] = vecs[v].f2;
      fs[3] = vecs[v].f3;
      @(posedge clk);
      #1;
      start_pass(vecs[v].sel, xs, fs);
      load(vecs[v].sel, xs, fs, 0, N, M, v[0]);
      wait_done(vecs[v].sel);
      chk("vec_count", pass_cnt[vecs[v].sel], vecs[v].cnt);
      chk("vec_y0", first_y[vecs[v].sel], vecs[v].y0);
      chk("vec_ylast", last_y[vecs[v].sel], vecs[v].ylast);
    end

    // Backpressure: y_ready held low for five cycles on the first output.
    fs = '{1, 2, 3, 4};
    @(posedge clk);
    #1;
    yr[0] = 1'b0;
    start_pass(0, ramp, fs);
    load(0, ramp, fs, 0, N, M, 1'b0);
    t = 0;
    while (!yv[0] && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!yv[0]) fail("bp_valid_timeout");
    d0 = int'($signed(yd[0]));
    l0 = int'(yl[0]);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", int'(yv[0]), 1);
      chk("bp_data", int'($signed(yd[0])), d0);
      chk("bp_last", int'(yl[0]), l0);
    end
    chk("bp_first_value", d0, 30);
    @(posedge clk);
    #1;
    yr[0] = 1'b1;
    wait_done(0);

    // Coefficients arrive ten cycles after the last sample.
    for (int k = 0; k < N; k++) rx[k] = int'($urandom_range(0, 255)) - 128;
    for (int k = 0; k < M; k++) rf[k] = int'($urandom_range(0, 255)) - 128;
    @(posedge clk);
    #1;
    start_pass(1, rx, rf);
    load(1, rx, rf, 10, N, M, 1'b0);
    wait_done(1);

    // Reset in the middle of a load, then a full fresh load.
    @(posedge clk);
    #1;
    load(1, ramp, fs, 0, 7, 2, 1'b0);
    reset_dut(1);
    for (int k = 0; k < N; k++) rx[k] = int'($urandom_range(0, 255)) - 128;
    for (int k = 0; k < M; k++) rf[k] = int'($urandom_range(0, 255)) - 128;
    start_pass(1, rx, rf);
    load(1, rx, rf, 0, N, M, 1'b1);
    wait_done(1);

    // Reset while y[3] is being accumulated.
    fs = '{1, 1, 1, 1};
    @(posedge clk);
    #1;
    start_pass(0, ramp, fs);
    load(0, ramp, fs, 0, N, M, 1'b0);
    t = 0;
    while (pass_cnt[0] < 3 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (pass_cnt[0] < 3) fail("mac_reset_wait_timeout");
    repeat (4) @(posedge clk);
    #1;
    rst[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs(0);
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    sbq0.delete();
    for (int k = 0; k < N; k++) rx[k] = int'($urandom_range(0, 255)) - 128;
    for (int k = 0; k < M; k++) rf[k] = int'($urandom_range(0, 255)) - 128;
    rf[0] = -3;
    start_pass(0, rx, rf);
    load(0, rx, rf, 0, N, M, 1'b1);
    wait_done(0);
    chk("post_reset_count", pass_cnt[0], 13);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv1d_stride.md
CONV1D_STRIDE -- requirements
Module: conv1d_stride

Interface
REQ-001 Parameter N, default 16: input vector length (N >= 2).
REQ-002 Parameter M, default 4: filter length (2 <= M <= N).
REQ-003 Parameter T, default 8: signed two's-complement data width for x, f and y.
REQ-004 Parameter S, default 1: stride; (N-M) SHALL be divisible by S; L = (N-M)/S + 1 outputs.
REQ-005 Parameter RELU, default 1: 1 clamps negative outputs to 0, 0 passes signed result.
REQ-006 clk  in  1  clock; all state changes on its rising edge.
REQ-007 reset  in  1  reset, synchronous, active-high.
REQ-008 x_data  in  T  signed input sample, element order x[0]..x[N-1].
REQ-009 x_valid / x_ready  in / out  1 each  input sample handshake.
REQ-010 f_data  in  T  signed filter coefficient, order f[0]..f[M-1].
REQ-011 f_valid / f_ready  in / out  1 each  coefficient handshake.
REQ-012 y_data  out  T  output sample y[n].
REQ-013 y_valid / y_ready  out / in  1 each  output handshake.
REQ-014 y_last  out  1  high with y_valid on y[L-1] only.

Function
REQ-015 Transfer occurs on a cycle where valid and ready are both high; no other cycle consumes or produces data.
REQ-016 States: IDLE (1 cycle after reset), LOAD, CLEAR, FILL, MAC, OUT.
REQ-017 LOAD: x_ready high while fewer than N x accepted; f_ready high while fewer than M f accepted; both streams load independently and concurrently.
REQ-018 LOAD exits to CLEAR on the cycle the later of the two final beats (x[N-1], f[M-1]) is accepted, including when both final beats arrive in the same cycle.
REQ-019 Filter RAM (M words) and x RAM (N words) SHALL have synchronous 1-cycle read; f SHALL be reloaded on every pass.
REQ-020 y[n] = sum over k=0..M-1 of x[n*S+k]*f[k], n = 0..L-1.
REQ-021 Each product saturates to [-2^(T-1), 2^(T-1)-1] and is registered; each accumulation saturates to the same range.
REQ-022 CLEAR zeroes the accumulator and issues k=0; FILL covers the product-register stage; MAC accumulates exactly M products.
REQ-023 y_valid SHALL rise exactly M+3 cycles after entry to CLEAR; compute latency per output is fixed regardless of data.
REQ-024 OUT: y_valid, y_data and y_last held stable until y_ready; on handshake go to CLEAR for n+1, or to LOAD after y[L-1].
REQ-025 y_ready high in the first OUT cycle completes the transfer in that cycle.
REQ-026 x_ready and f_ready SHALL be 0 outside LOAD; x_valid and f_valid outside LOAD are ignored.
REQ-027 Reading addresses x[n*S+k] SHALL never exceed N-1; address counters sized ceil(log2) plus 1 guard bit.

Reset
REQ-028 reset SHALL return to IDLE regardless of state, including mid-LOAD and mid-MAC; partial loads are discarded.
REQ-029 Reset values: x_ready=0, f_ready=0, y_valid=0, y_last=0, y_data=0, accumulator=0, all counters=0.
REQ-030 RAM contents need not be cleared; the first pass after reset SHALL reload all N x and M f.

Verification
REQ-031 N=16,M=4,T=8,S=1, x=1..16, f={1,1,1,1}, y_ready=1 -> y=10,14,...,58 (13 outputs), y_last on 58, each y_valid M+3=7 cycles after CLEAR.
REQ-032 Same data, S=2 -> 7 outputs 10,18,26,34,42,50,58; y_last on 58.
REQ-033 x all 127, f all 127 -> every y = 127 (product and accumulator saturation); x all 127, f all -128, RELU=0 -> every y = -128.
REQ-034 f={-1,-1,-1,-1}, x=1..16: RELU=1 -> all y=0; RELU=0 -> y[0]=-10, y[12]=-58.
REQ-035 y_ready low 5 cycles in OUT -> y_valid, y_data, y_last stable; f sent 10 cycles after x complete -> CLEAR entered the cycle after f[3] accepted.
REQ-036 reset asserted mid-MAC of y[3] -> next cycle all outputs at reset values; fresh load of new x/f yields correct y[0] with no stale data.
